// File: rtl/gam_learning_sequencer_pkg.sv
// gam_learning_sequencer_pkg: shared types and defaults for the GAM training sequencer.
package gam_learning_sequencer_pkg;
    localparam int NODE_W = 8;
    localparam int GAM_SEQ_HOLD_CYC = 4;
    typedef logic [NODE_W-1:0] node_vector_T;
    typedef enum logic [2:0] {
        IDLE, FEED, HOLD, LEARN_DONE, ASSOC_START, ASSOC_WAIT, FINISH
    } gam_seq_state_T;
endpackage

// File: rtl/gam_learning_sequencer.sv
// gam_learning_sequencer: feeds one GAM training session to the memory layer, then runs the assoc phase.
// Define GAM_SEQ_TIMEOUT_EN to add the assoc-phase watchdog and the timeout_err port.
module gam_learning_sequencer
    import gam_learning_sequencer_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int HOLD_CYC    = GAM_SEQ_HOLD_CYC,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               s_valid,
    input  node_vector_T       s_x,
    input  logic [31:0]        s_class,
    output logic               s_ready,
    output node_vector_T       mem_x,
    output logic [31:0]        mem_c,
    output logic               mem_learning_done,
    output logic               mem_assoc_learning_start,
    input  logic               mem_assoc_learning_done,
    output logic               busy,
    output logic               done,
`ifdef GAM_SEQ_TIMEOUT_EN
    output logic               timeout_err,
`endif
    output logic [CNT_W-1:0]   sample_count
);
    localparam int MAXC = HOLD_CYC > TIMEOUT_CYC ? HOLD_CYC : TIMEOUT_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    gam_seq_state_T   state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d, count_q, count_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    node_vector_T     mem_x_q, mem_x_d;
    logic [31:0]      mem_c_q, mem_c_d;
    logic             learn_q, learn_d, astart_q, astart_d, done_q, done_d, busy_q, busy_d;
`ifdef GAM_SEQ_TIMEOUT_EN
    logic             tmo_q, tmo_d;
    assign timeout_err = tmo_q;
`endif
    assign s_ready                  = state_q == FEED;
    assign mem_x                    = mem_x_q;
    assign mem_c                    = mem_c_q;
    assign mem_learning_done        = learn_q;
    assign mem_assoc_learning_start = astart_q;
    assign busy                     = busy_q;
    assign done                     = done_q;
    assign sample_count             = count_q;
    // One down-counter serves both the per-sample hold window and the assoc watchdog.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        mem_x_d = mem_x_q;
        mem_c_d = mem_c_q;
`ifdef GAM_SEQ_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: if (start && num_samples != '0) begin
                n_d     = num_samples;
                count_d = '0;
`ifdef GAM_SEQ_TIMEOUT_EN
                tmo_d   = 1'b0;
`endif
                state_d = FEED;
            end
            FEED: if (s_valid) begin
                mem_x_d = s_x;
                mem_c_d = s_class;
                count_d = count_q + 1'b1;
                cnt_d   = CW'(HOLD_CYC - 1);
                state_d = HOLD;
            end
            HOLD: if (cnt_q == '0) state_d = count_q == n_q ? LEARN_DONE : FEED;
                  else cnt_d = cnt_q - 1'b1;
            LEARN_DONE: state_d = ASSOC_START;
            ASSOC_START: begin
                state_d = ASSOC_WAIT;
`ifdef GAM_SEQ_TIMEOUT_EN
                cnt_d   = CW'(TIMEOUT_CYC - 1);
`endif
            end
            ASSOC_WAIT: if (mem_assoc_learning_done) state_d = FINISH;
`ifdef GAM_SEQ_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    tmo_d   = 1'b1;
                    state_d = FINISH;
                end else cnt_d = cnt_q - 1'b1;
`endif
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        learn_d  = state_d inside {LEARN_DONE, ASSOC_START, ASSOC_WAIT, FINISH};
        astart_d = state_d == ASSOC_START;
        done_d   = state_d == FINISH;
        busy_d   = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            n_q      <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            mem_x_q  <= '0;
            mem_c_q  <= '0;
            learn_q  <= 1'b0;
            astart_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef GAM_SEQ_TIMEOUT_EN
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            mem_x_q  <= mem_x_d;
            mem_c_q  <= mem_c_d;
            learn_q  <= learn_d;
            astart_q <= astart_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef GAM_SEQ_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end
endmodule

// File: tb/tb_gam_learning_sequencer.sv
// tb_gam_learning_sequencer: randomized sessions checked against a cycle timeline derived from the session rules.
module tb_gam_learning_sequencer;
    import gam_learning_sequencer_pkg::*;
    localparam int CNT_W = 16;
    localparam int HOLD  = 4;
    localparam int TMO   = 16;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, s_valid = 1'b0, mem_assoc_learning_done = 1'b0;
    logic s_ready, mem_learning_done, mem_assoc_learning_start, busy, done;
    logic [CNT_W-1:0] num_samples = '0, sample_count;
    node_vector_T s_x = '0, mem_x, last_x = '0;
    logic [31:0] s_class = '0, mem_c, last_c = '0;
    int n_chk = 0, n_pass = 0, last_n = 0;
`ifdef GAM_SEQ_TIMEOUT_EN
    logic timeout_err;
    bit exp_tmo = 1'b0;
`endif
    always #5 clk = ~clk;
    gam_learning_sequencer #(.CNT_W(CNT_W), .HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .num_samples(num_samples),
        .s_valid(s_valid), .s_x(s_x), .s_class(s_class), .s_ready(s_ready),
        .mem_x(mem_x), .mem_c(mem_c), .mem_learning_done(mem_learning_done),
        .mem_assoc_learning_start(mem_assoc_learning_start),
        .mem_assoc_learning_done(mem_assoc_learning_done), .busy(busy), .done(done),
`ifdef GAM_SEQ_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .sample_count(sample_count)
    );
    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask
    // Inputs the sequencer must ignore in the current phase are driven with noise.
    task automatic junk(input bit hold);
        start = 1'($urandom);
        num_samples = CNT_W'($urandom);
        mem_assoc_learning_done = 1'($urandom);
        s_valid = hold ? 1'($urandom) : 1'b0;
        s_x = node_vector_T'($urandom);
        s_class = $urandom;
    endtask
    task automatic outs(input string ph, input bit rdy, input bit ld, input bit as, input bit dn, input bit bz, input int cnt);
        chk({ph, ".s_ready"}, s_ready, rdy);
        chk({ph, ".learning_done"}, mem_learning_done, ld);
        chk({ph, ".assoc_start"}, mem_assoc_learning_start, as);
        chk({ph, ".done"}, done, dn);
        chk({ph, ".busy"}, busy, bz);
        chk({ph, ".sample_count"}, sample_count, cnt);
        chk({ph, ".mem_x"}, mem_x, last_x);
        chk({ph, ".mem_c"}, mem_c, last_c);
`ifdef GAM_SEQ_TIMEOUT_EN
        chk({ph, ".timeout_err"}, timeout_err, exp_tmo);
`endif
    endtask
    task automatic session(input int n, input int fixg, input bit basic, input int d, input bit to, input int rst_at);
        node_vector_T x;
        logic [31:0] c;
        int g;
        start = 1'b1;
        num_samples = CNT_W'(n);
        s_valid = 1'b0;
        mem_assoc_learning_done = 1'($urandom);
        tick;
        start = 1'b0;
`ifdef GAM_SEQ_TIMEOUT_EN
        exp_tmo = 1'b0;
`endif
        outs("start", 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < n; i++) begin
            g = fixg >= 0 ? fixg : $urandom_range(3, 0);
            for (int k = 0; k < g; k++) begin
                junk(1'b0);
                tick;
                outs("feed", 1, 0, 0, 0, 1, i);
            end
            x = basic ? node_vector_T'(1 << i) : node_vector_T'($urandom);
            c = basic ? i : $urandom;
            s_valid = 1'b1;
            s_x = x;
            s_class = c;
            tick;
            last_x = x;
            last_c = c;
            for (int k = 0; k < HOLD; k++) begin
                outs("hold", 0, 0, 0, 0, 1, i + 1);
                if (i == rst_at && k == 1) begin
                    junk(1'b1);
                    reset = 1'b0;
                    tick;
                    reset = 1'b1;
                    start = 1'b0;
                    s_valid = 1'b0;
                    mem_assoc_learning_done = 1'b0;
                    last_x = '0;
                    last_c = '0;
                    last_n = 0;
`ifdef GAM_SEQ_TIMEOUT_EN
                    exp_tmo = 1'b0;
`endif
                    outs("rst", 0, 0, 0, 0, 0, 0);
                    tick;
                    outs("rst_after", 0, 0, 0, 0, 0, 0);
                    return;
                end
                junk(1'b1);
                tick;
            end
        end
        outs("learn", 0, 1, 0, 0, 1, n);
        mem_assoc_learning_done = 1'($urandom);
        tick;
        outs("astart", 0, 1, 1, 0, 1, n);
        mem_assoc_learning_done = 1'b0;
        s_valid = 1'b0;
        tick;
        for (int j = 0; j < (to ? TMO : d); j++) begin
            outs("wait", 0, 1, 0, 0, 1, n);
            start = 1'($urandom);
            tick;
        end
        if (!to) begin
            mem_assoc_learning_done = 1'b1;
            tick;
        end
`ifdef GAM_SEQ_TIMEOUT_EN
        exp_tmo = to;
`endif
        start = 1'b0;
        mem_assoc_learning_done = 1'b0;
        outs("finish", 0, 1, 0, 1, 1, n);
        tick;
        outs("idle", 0, 0, 0, 0, 0, n);
        last_n = n;
    endtask
    initial begin
        repeat (3) tick;
        outs("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick;
        outs("reset_rel", 0, 0, 0, 0, 0, 0);
        session(3, 0, 1'b1, 4, 1'b0, -1);
        session(3, 6, 1'b0, 2, 1'b0, -1);
        start = 1'b1;
        num_samples = '0;
        tick;
        start = 1'b0;
        outs("zero_n", 0, 0, 0, 0, 0, last_n);
        tick;
        outs("zero_n2", 0, 0, 0, 0, 0, last_n);
        session(3, -1, 1'b0, 3, 1'b0, 1);
        session(1, -1, 1'b0, 0, 1'b0, -1);
        for (int s = 0; s < 6; s++)
            session($urandom_range(5, 1), -1, 1'b0, $urandom_range(6, 0), 1'b0, -1);
`ifdef GAM_SEQ_TIMEOUT_EN
        session(2, -1, 1'b0, 0, 1'b1, -1);
        session(1, 0, 1'b0, 1, 1'b0, -1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
